// File: rtl/wave_meas_sched.sv
// rtl/wave_meas_sched.sv - round-robin sharing of one wave measurement engine among NUM_CH channels
// Latches rising-edge requests, settles the analog mux, runs one engine window and returns a tagged result.
module wave_meas_sched #(
   parameter int NUM_CH         = 4,
   parameter int CH_W           = 2,
   parameter int N              = 8,
   parameter int SETTLE_CYCLES  = 20,
   parameter int TMO_W          = 20,
   parameter int TIMEOUT_CYCLES = 800000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NUM_CH-1:0] req,
   input  logic              ana_done,
   input  logic [N-1:0]      ana_vpp,
   input  logic [N-1:0]      ana_dc,
   input  logic [N-1:0]      ana_papr,
   input  logic              ana_is_sine,
   output logic [CH_W-1:0]   mux_sel,
   output logic              ana_start,
   output logic [NUM_CH-1:0] pending,
   output logic              busy,
   output logic              res_valid,
   output logic [CH_W-1:0]   res_ch,
   output logic [N-1:0]      res_vpp,
   output logic [N-1:0]      res_dc,
   output logic [N-1:0]      res_papr,
   output logic              res_is_sine,
   output logic              res_err
);

   localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES + 1) : 1;
   localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYCLES - 1);
   // Counter starts at 0 in the first WAIT_DONE cycle, so abort on the cycle it would step to TIMEOUT_CYCLES-1.
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 2);

   typedef enum logic [2:0] {S_IDLE, S_SETTLE, S_START, S_WAIT_DONE, S_REPORT} state_t;

   state_t              state, state_nxt;
   logic [NUM_CH-1:0]   req_q;
   logic [CH_W-1:0]     rr;
   logic [SET_W-1:0]    settle_cnt;
   logic [TMO_W-1:0]    tmo_cnt;
   logic [NUM_CH-1:0]   clr_mask;
   logic [2*NUM_CH-1:0] pend2;
   logic [2*NUM_CH-1:0] rot;
   logic [CH_W-1:0]     grant;
   logic                grant_vld;
   logic                tmo_hit;
   int                  off;
   int                  g;

   // Rotate pending so the channel after the last grant sits at bit 0, then take the lowest set bit.
   always_comb begin
      pend2     = {pending, pending};
      rot       = pend2 >> (int'(rr) + 1);
      grant_vld = 1'b0;
      off       = 0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (rot[i]) begin
            grant_vld = 1'b1;
            off       = i;
         end
      end
      g = int'(rr) + 1 + off;
      if (g >= NUM_CH) g = g - NUM_CH;
      grant = CH_W'(g);
   end

   always_comb begin
      clr_mask = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         clr_mask[i] = (state == S_REPORT) && (mux_sel == CH_W'(i));
      end
   end

   assign tmo_hit = (tmo_cnt == TMO_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:      if (grant_vld) state_nxt = S_SETTLE;
         S_SETTLE:    if (settle_cnt == SET_LAST) state_nxt = S_START;
         S_START:     state_nxt = S_WAIT_DONE;
         S_WAIT_DONE: if (ana_done || tmo_hit) state_nxt = S_REPORT;
         S_REPORT:    state_nxt = S_IDLE;
         default:     state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      ana_start = (state == S_START);
      res_valid = (state == S_REPORT);
      busy      = (state != S_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         req_q       <= '0;
         pending     <= '0;
         rr          <= CH_W'(NUM_CH - 1);
         mux_sel     <= '0;
         settle_cnt  <= '0;
         tmo_cnt     <= '0;
         res_ch      <= '0;
         res_vpp     <= '0;
         res_dc      <= '0;
         res_papr    <= '0;
         res_is_sine <= 1'b0;
         res_err     <= 1'b0;
      end else begin
         req_q   <= req;
         // New rising edge wins over the REPORT clear of the same channel.
         pending <= (pending & ~clr_mask) | (req & ~req_q);
         case (state)
            S_IDLE: begin
               if (grant_vld) begin
                  mux_sel    <= grant;
                  rr         <= grant;
                  settle_cnt <= '0;
               end
            end
            S_SETTLE: settle_cnt <= settle_cnt + 1'b1;
            S_START:  tmo_cnt    <= '0;
            S_WAIT_DONE: begin
               if (ana_done) begin
                  res_ch      <= mux_sel;
                  res_vpp     <= ana_vpp;
                  res_dc      <= ana_dc;
                  res_papr    <= ana_papr;
                  res_is_sine <= ana_is_sine;
                  res_err     <= 1'b0;
               end else if (tmo_hit) begin
                  res_ch      <= mux_sel;
                  res_vpp     <= '0;
                  res_dc      <= '0;
                  res_papr    <= '0;
                  res_is_sine <= 1'b0;
                  res_err     <= 1'b1;
               end else begin
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_wave_meas_sched.sv
// tb/tb_wave_meas_sched.sv - directed self-checking bench for wave_meas_sched
module tb_wave_meas_sched;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] req;
   logic       ana_done;
   logic [7:0] ana_vpp, ana_dc, ana_papr;
   logic       ana_is_sine;
   logic [1:0] mux_sel;
   logic       ana_start;
   logic [3:0] pending;
   logic       busy;
   logic       res_valid;
   logic [1:0] res_ch;
   logic [7:0] res_vpp, res_dc, res_papr;
   logic       res_is_sine;
   logic       res_err;

   int n_checks = 0;
   int n_fail   = 0;
   int vcount   = 0;

   wave_meas_sched #(
      .NUM_CH(4), .CH_W(2), .N(8), .SETTLE_CYCLES(20), .TMO_W(20), .TIMEOUT_CYCLES(1000)
   ) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .ana_done(ana_done),
      .ana_vpp(ana_vpp), .ana_dc(ana_dc), .ana_papr(ana_papr), .ana_is_sine(ana_is_sine),
      .mux_sel(mux_sel), .ana_start(ana_start), .pending(pending), .busy(busy),
      .res_valid(res_valid), .res_ch(res_ch), .res_vpp(res_vpp), .res_dc(res_dc),
      .res_papr(res_papr), .res_is_sine(res_is_sine), .res_err(res_err)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (res_valid === 1'b1) vcount++;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic pulse_req(input logic [3:0] r);
      req = r;
      @(negedge clk);
      req = 4'b0000;
   endtask

   // Waits for the window start, answers it with the given data and checks the REPORT cycle.
   task automatic serve(input string tag, input int ch, input logic [7:0] v, input logic [7:0] d,
                        input logic [7:0] p, input logic s);
      int n;
      n = 0;
      while (ana_start !== 1'b1 && n < 400) begin
         @(negedge clk);
         n++;
      end
      check_eq({tag, "_start_seen"}, 32'(n < 400), 32'd1);
      check_eq({tag, "_mux_sel"}, 32'(mux_sel), 32'(ch));
      repeat (5) @(negedge clk);
      ana_done = 1'b1; ana_vpp = v; ana_dc = d; ana_papr = p; ana_is_sine = s;
      @(negedge clk);
      ana_done = 1'b0;
      check_eq({tag, "_res_valid"}, 32'(res_valid), 32'd1);
      check_eq({tag, "_res_ch"}, 32'(res_ch), 32'(ch));
      check_eq({tag, "_res_vpp"}, 32'(res_vpp), 32'(v));
      check_eq({tag, "_res_dc"}, 32'(res_dc), 32'(d));
      check_eq({tag, "_res_papr"}, 32'(res_papr), 32'(p));
      check_eq({tag, "_res_sine"}, 32'(res_is_sine), 32'(s));
      check_eq({tag, "_res_err"}, 32'(res_err), 32'd0);
   endtask

   initial begin
      int n;
      int base;
      rst_n = 1'b0; req = '0; ana_done = 1'b0;
      ana_vpp = '0; ana_dc = '0; ana_papr = '0; ana_is_sine = 1'b0;
      repeat (3) @(negedge clk);
      check_eq("rst_mux_sel", 32'(mux_sel), 32'd0);
      check_eq("rst_busy", 32'(busy), 32'd0);
      check_eq("rst_pending", 32'(pending), 32'd0);
      check_eq("rst_ana_start", 32'(ana_start), 32'd0);
      check_eq("rst_res_valid", 32'(res_valid), 32'd0);
      check_eq("rst_res_err", 32'(res_err), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Single request on ch2: latency and captured fields
      pulse_req(4'b0100);
      check_eq("t1_pending", 32'(pending), 32'h4);
      check_eq("t1_idle_grant", 32'(busy), 32'd0);
      n = 0;
      while (ana_start !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      check_eq("t1_start_latency", 32'(n), 32'd21);
      check_eq("t1_mux_sel", 32'(mux_sel), 32'd2);
      check_eq("t1_busy", 32'(busy), 32'd1);
      repeat (100) @(negedge clk);
      ana_done = 1'b1; ana_vpp = 8'hC8; ana_dc = 8'h80; ana_papr = 8'h08; ana_is_sine = 1'b1;
      @(negedge clk);
      ana_done = 1'b0;
      check_eq("t1_res_valid", 32'(res_valid), 32'd1);
      check_eq("t1_res_ch", 32'(res_ch), 32'd2);
      check_eq("t1_res_vpp", 32'(res_vpp), 32'hC8);
      check_eq("t1_res_dc", 32'(res_dc), 32'h80);
      check_eq("t1_res_papr", 32'(res_papr), 32'h08);
      check_eq("t1_res_sine", 32'(res_is_sine), 32'd1);
      check_eq("t1_res_err", 32'(res_err), 32'd0);
      @(negedge clk);
      check_eq("t1_pending_clr", 32'(pending), 32'd0);
      check_eq("t1_valid_one_clk", 32'(res_valid), 32'd0);
      check_eq("t1_res_hold", 32'(res_vpp), 32'hC8);

      // All four at once right after reset: order 0,1,2,3
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      base = vcount;
      pulse_req(4'b1111);
      serve("t2_c0", 0, 8'h11, 8'h12, 8'h13, 1'b0);
      serve("t2_c1", 1, 8'h21, 8'h22, 8'h23, 1'b1);
      serve("t2_c2", 2, 8'h31, 8'h32, 8'h33, 1'b0);
      serve("t2_c3", 3, 8'h41, 8'h42, 8'h43, 1'b1);
      @(negedge clk);
      check_eq("t2_busy_low", 32'(busy), 32'd0);
      check_eq("t2_pending", 32'(pending), 32'd0);
      check_eq("t2_valid_count", 32'(vcount - base), 32'd4);

      // Rotation past the last grant: after ch1, ch3 beats ch1
      pulse_req(4'b0010);
      serve("t3_c1", 1, 8'h51, 8'h52, 8'h53, 1'b0);
      @(negedge clk);
      pulse_req(4'b1010);
      serve("t3_c3", 3, 8'h61, 8'h62, 8'h63, 1'b1);
      serve("t3_c1b", 1, 8'h71, 8'h72, 8'h73, 1'b0);
      @(negedge clk);

      // Timeout on ch2, then ch0 still served
      pulse_req(4'b0101);
      n = 0;
      while (ana_start !== 1'b1 && n < 400) begin
         @(negedge clk);
         n++;
      end
      check_eq("t4_mux_sel", 32'(mux_sel), 32'd2);
      n = 0;
      while (res_valid !== 1'b1 && n < 1200) begin
         @(negedge clk);
         n++;
      end
      check_eq("t4_tmo_latency", 32'(n), 32'd1000);
      check_eq("t4_res_err", 32'(res_err), 32'd1);
      check_eq("t4_res_ch", 32'(res_ch), 32'd2);
      check_eq("t4_res_vpp", 32'(res_vpp), 32'd0);
      check_eq("t4_res_dc", 32'(res_dc), 32'd0);
      check_eq("t4_res_papr", 32'(res_papr), 32'd0);
      check_eq("t4_res_sine", 32'(res_is_sine), 32'd0);
      serve("t4_c0", 0, 8'h81, 8'h82, 8'h83, 1'b1);
      @(negedge clk);

      // Stale done in SETTLE ignored; re-request in REPORT keeps ch0 pending
      base = vcount;
      pulse_req(4'b0001);
      repeat (5) @(negedge clk);
      ana_done = 1'b1; ana_vpp = 8'hFF; ana_dc = 8'hFF; ana_papr = 8'hFF; ana_is_sine = 1'b0;
      @(negedge clk);
      ana_done = 1'b0;
      @(negedge clk);
      check_eq("t5_stale_busy", 32'(busy), 32'd1);
      check_eq("t5_stale_no_valid", 32'(vcount - base), 32'd0);
      check_eq("t5_stale_no_capture", 32'(res_vpp), 32'h81);
      serve("t5_c0", 0, 8'h91, 8'h92, 8'h93, 1'b0);
      req = 4'b0001;
      @(negedge clk);
      req = 4'b0000;
      check_eq("t5_pending_kept", 32'(pending), 32'h1);
      serve("t5_c0_again", 0, 8'hA1, 8'hA2, 8'hA3, 1'b1);
      @(negedge clk);

      // Reset during WAIT_DONE
      pulse_req(4'b1000);
      n = 0;
      while (ana_start !== 1'b1 && n < 400) begin
         @(negedge clk);
         n++;
      end
      check_eq("t6_start_seen", 32'(n < 400), 32'd1);
      repeat (5) @(negedge clk);
      pulse_req(4'b0010);
      #2 rst_n = 1'b0;
      #1;
      check_eq("t6_busy", 32'(busy), 32'd0);
      check_eq("t6_pending", 32'(pending), 32'd0);
      check_eq("t6_mux_sel", 32'(mux_sel), 32'd0);
      check_eq("t6_ana_start", 32'(ana_start), 32'd0);
      check_eq("t6_res_valid", 32'(res_valid), 32'd0);
      check_eq("t6_res_vpp", 32'(res_vpp), 32'd0);
      check_eq("t6_res_sine", 32'(res_is_sine), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      base = vcount;
      repeat (50) @(negedge clk);
      check_eq("t6_no_valid_after", 32'(vcount - base), 32'd0);
      check_eq("t6_idle_after", 32'(busy), 32'd0);
      pulse_req(4'b0100);
      serve("t6_recover", 2, 8'hB1, 8'hB2, 8'hB3, 1'b0);
      @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
